// File: rtl/sdio_cmd_rx.sv
// Card-side SDIO CMD-line receiver: oversamples sd_ck/sd_cmd in the system
// clock, deserialises 48-bit host command frames, checks CRC7 and the end
// bit, and presents index/argument on a valid/ready interface.
module sdio_cmd_rx #(
    parameter int NSYNC   = 2,
    parameter bit OPT_CRC = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_sd_ck,
    input  logic        i_sd_cmd,
    input  logic        i_enable,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [5:0]  o_index,
    output logic [31:0] o_arg,
    output logic        o_crc_err,
    output logic        o_end_err,
    output logic        o_overflow
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIR,
        ST_BODY,
        ST_CRC,
        ST_END,
        ST_SKIP
    } state_t;

    // One CRC7 step, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    logic [NSYNC-1:0] ck_sync;
    logic [NSYNC-1:0] cmd_sync;
    logic             ck_prev;
    logic             ck_s;
    logic             cmd_s;
    logic             bit_en;

    state_t           state;
    state_t           state_next;
    logic [5:0]       bit_cnt;
    logic [37:0]      body_sr;
    logic [6:0]       rx_crc;
    logic [6:0]       calc_crc;
    logic             crc_mismatch;
    logic             frame_done;

    // Synchronise sd_ck and sd_cmd through matched chains; idle level is 1.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, exactly like hardware.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ck_sync  <= '1;
            cmd_sync <= '1;
            ck_prev  <= 1'b1;
        end else begin
            ck_sync  <= {ck_sync[NSYNC-2:0], i_sd_ck};
            cmd_sync <= {cmd_sync[NSYNC-2:0], i_sd_cmd};
            ck_prev  <= ck_s;
        end
    end

    // CMD is taken from the same stage as the clock so both see equal delay.
    assign ck_s   = ck_sync[NSYNC-1];
    assign cmd_s  = cmd_sync[NSYNC-1];
    assign bit_en = ck_s & ~ck_prev;

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= ST_IDLE;
        else            state <= state_next;
    end

    // Next-state logic; a low enable aborts any frame in progress.
    // NOTE: state_next gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (!i_enable) begin
            state_next = ST_IDLE;
        end else if (bit_en) begin
            case (state)
                ST_IDLE: if (!cmd_s) state_next = ST_DIR;
                ST_DIR:  state_next = cmd_s ? ST_BODY : ST_SKIP;
                ST_BODY: if (bit_cnt == 6'd37) state_next = ST_CRC;
                ST_CRC:  if (bit_cnt == 6'd6)  state_next = ST_END;
                ST_END:  state_next = ST_IDLE;
                ST_SKIP: if (bit_cnt == 6'd45) state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Bit counter restarts on every state change and counts within a state.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bit_cnt <= '0;
        end else if (bit_en) begin
            if (state_next == state && state != ST_IDLE) bit_cnt <= bit_cnt + 6'd1;
            else                                         bit_cnt <= '0;
        end
    end

    // Shift index/argument and received CRC; run the CRC over start..arg.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            body_sr  <= '0;
            rx_crc   <= '0;
            calc_crc <= '0;
        end else if (bit_en && i_enable) begin
            case (state)
                ST_IDLE: if (!cmd_s) calc_crc <= crc7_next(7'd0, cmd_s);
                ST_DIR:  if (cmd_s)  calc_crc <= crc7_next(calc_crc, cmd_s);
                ST_BODY: begin
                    body_sr  <= {body_sr[36:0], cmd_s};
                    calc_crc <= crc7_next(calc_crc, cmd_s);
                end
                ST_CRC:  rx_crc <= {rx_crc[5:0], cmd_s};
                default: ;
            endcase
        end
    end

    assign crc_mismatch = OPT_CRC && (rx_crc != calc_crc);
    assign frame_done   = bit_en && i_enable && (state == ST_END);

    // Output holding register with valid/ready handshake and sticky overflow.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid    <= 1'b0;
            o_index    <= '0;
            o_arg      <= '0;
            o_crc_err  <= 1'b0;
            o_end_err  <= 1'b0;
            o_overflow <= 1'b0;
        end else if (frame_done) begin
            if (!o_valid || i_ready) begin
                o_valid   <= 1'b1;
                o_index   <= body_sr[37:32];
                o_arg     <= body_sr[31:0];
                o_crc_err <= crc_mismatch;
                o_end_err <= ~cmd_s;
            end else begin
                o_overflow <= 1'b1;
            end
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdio_cmd_rx.sv
// Self-checking bench for sdio_cmd_rx: directed frames from the test plan
// followed by random command frames, checked against a frame-level model.
`timescale 1ns/1ps
module tb_sdio_cmd_rx;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic        ce;
        logic        ee;
    } rec_t;

    logic        clk;
    logic        rst_n;
    logic        sd_ck;
    logic        sd_cmd;
    logic        enable;
    logic        valid;
    logic        ready;
    logic [5:0]  index;
    logic [31:0] arg;
    logic        crc_err;
    logic        end_err;
    logic        overflow;

    int   checks = 0;
    int   errors = 0;
    rec_t got_q[$];

    sdio_cmd_rx #(.NSYNC(2), .OPT_CRC(1'b1)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_sd_ck    (sd_ck),
        .i_sd_cmd   (sd_cmd),
        .i_enable   (enable),
        .o_valid    (valid),
        .i_ready    (ready),
        .o_index    (index),
        .o_arg      (arg),
        .o_crc_err  (crc_err),
        .o_end_err  (end_err),
        .o_overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every frame the consumer accepts.
    always @(negedge clk) begin
        if (rst_n && valid && ready) got_q.push_back('{index, arg, crc_err, end_err});
    end

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] crc7_div(input logic [39:0] m);
        logic [46:0] v;
        v = {m, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
        return v[6:0];
    endfunction

    // What a command frame should decode to.
    function automatic rec_t model(input logic [47:0] f);
        rec_t r;
        r.idx = f[45:40];
        r.arg = f[39:8];
        r.ce  = (f[7:1] != crc7_div(f[47:8]));
        r.ee  = ~f[0];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bits(input logic [47:0] f, input int n);
        for (int i = 47; i > 47 - n; i--) begin
            sd_cmd = f[i];
            #50 sd_ck = 1'b1;
            #50 sd_ck = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            sd_cmd = 1'b1;
            #50 sd_ck = 1'b1;
            #50 sd_ck = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [47:0] f);
        send_bits(f, 48);
        idle(2);
    endtask

    task automatic expect_frame(input string tag, input logic [47:0] f);
        rec_t r;
        check({tag, "_avail"}, 64'(got_q.size() != 0), 64'd1);
        if (got_q.size() != 0) begin
            r = got_q.pop_front();
            check(tag, 64'(r), 64'(model(f)));
        end
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (valid) break;
            @(negedge clk);
        end
        check({tag, "_valid"}, 64'(valid), 64'd1);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 ready = v;
    endtask

    initial begin
        logic [47:0] f_cmd0, f_cmd8, f_crcbad, f_endbad, f_resp, f_cmd17, f_rnd;
        logic [5:0]  r_idx;
        logic [31:0] r_arg;
        logic [6:0]  r_crc;
        rec_t        held;

        f_cmd0   = 48'h40_0000_0000_95;
        f_cmd8   = 48'h48_0000_01AA_87;
        f_crcbad = 48'h51_0000_0000_57;
        f_endbad = 48'h40_0000_0000_94;
        f_resp   = 48'h3F_1234_5678_FF;
        f_cmd17  = 48'h51_0000_0000_55;

        rst_n  = 1'b0;
        sd_ck  = 1'b0;
        sd_cmd = 1'b1;
        enable = 1'b1;
        ready  = 1'b1;
        #23;
        check("rst_outputs", {valid, index, arg, crc_err, end_err, overflow}, 64'd0);
        rst_n = 1'b1;
        idle(3);

        // CMD0 with consumer always ready.
        send_frame(f_cmd0);
        expect_frame("cmd0", f_cmd0);
        check("cmd0_single", 64'(got_q.size()), 64'd0);
        check("cmd0_no_ovf", 64'(overflow), 64'd0);

        // CMD8 held while the consumer stalls.
        set_ready(1'b0);
        send_frame(f_cmd8);
        wait_valid("cmd8", 40);
        held = model(f_cmd8);
        check("cmd8_held", {index, arg, crc_err, end_err}, 64'(held));
        repeat (10) @(negedge clk);
        check("cmd8_stall_valid", 64'(valid), 64'd1);
        check("cmd8_stall_stable", {index, arg, crc_err, end_err}, 64'(held));
        set_ready(1'b1);
        repeat (3) @(negedge clk);
        check("cmd8_released", 64'(valid), 64'd0);
        expect_frame("cmd8", f_cmd8);

        // Corrupted CRC field, then end bit forced low.
        send_frame(f_crcbad);
        expect_frame("crc_bad", f_crcbad);
        send_frame(f_endbad);
        expect_frame("end_bad", f_endbad);

        // A response frame is skipped entirely, then CMD0 decodes.
        send_frame(f_resp);
        check("resp_skipped", 64'(got_q.size()), 64'd0);
        send_frame(f_cmd0);
        expect_frame("after_resp", f_cmd0);

        // Two back-to-back frames with no consumer: first held, second dropped.
        set_ready(1'b0);
        send_bits(f_cmd8, 48);
        send_frame(f_cmd0);
        wait_valid("ovf", 40);
        check("ovf_held", {index, arg, crc_err, end_err}, 64'(model(f_cmd8)));
        check("ovf_flag", 64'(overflow), 64'd1);
        set_ready(1'b1);
        idle(1);
        expect_frame("ovf_first", f_cmd8);
        check("ovf_only_one", 64'(got_q.size()), 64'd0);

        // Enable dropped at bit 20 aborts the frame.
        send_bits(f_cmd17, 20);
        enable = 1'b0;
        idle(3);
        enable = 1'b1;
        idle(2);
        send_frame(f_cmd8);
        expect_frame("after_enable", f_cmd8);
        check("enable_only_one", 64'(got_q.size()), 64'd0);

        // Reset pulsed mid-frame clears everything at once.
        send_bits(f_cmd17, 30);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {valid, index, arg, crc_err, end_err, overflow}, 64'd0);
        #20 rst_n = 1'b1;
        idle(3);
        send_frame(f_cmd17);
        expect_frame("after_reset", f_cmd17);
        check("after_reset_no_ovf", 64'(overflow), 64'd0);

        // Random command frames with occasional CRC or end-bit corruption.
        for (int n = 0; n < 12; n++) begin
            r_idx = 6'($urandom);
            r_arg = $urandom;
            r_crc = crc7_div({2'b01, r_idx, r_arg});
            if ($urandom_range(0, 3) == 0) r_crc = r_crc ^ (7'd1 << $urandom_range(0, 6));
            f_rnd = {2'b01, r_idx, r_arg, r_crc, 1'($urandom_range(0, 3) != 0)};
            send_bits(f_rnd, 48);
            idle($urandom_range(0, 3) + 2);
            expect_frame($sformatf("rnd%0d", n), f_rnd);
        end
        check("rnd_no_extra", 64'(got_q.size()), 64'd0);
        check("final_no_ovf", 64'(overflow), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
